// File: rtl/hash_msg_feeder.sv
// Byte-stream front-end for the 4-byte light hash core: packs bytes into padded blocks,
// chains block digests as IVs and presents the final 32-bit digest per message.
// Byte ordering: byte 0 (first byte / IV[0]) sits in bits [31:24] of every 32-bit bus.
module hash_msg_feeder #(
  parameter logic [31:0] IV_INIT  = 32'h34550F14,
  parameter int          WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        h_start,
  output logic [31:0] h_m,
  output logic [31:0] h_iv,
  input  logic [31:0] h_d,
  input  logic        h_done,
  output logic [31:0] digest,
  output logic        digest_valid,
  output logic [15:0] blk_cnt,
  output logic        err
);

  localparam int CW = $clog2(WAIT_MAX + 2);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [31:0]   blk_buf_q;
  logic [31:0]   blk_buf_d;
  logic [31:0]   chain_q;
  logic          final_q;
  logic          pad_blk_q;
  logic [CW-1:0] wait_cnt_q;
  logic          h_start_q;
  logic [31:0]   h_m_q;
  logic [31:0]   h_iv_q;
  logic [31:0]   digest_q;
  logic          digest_valid_q;
  logic [15:0]   blk_cnt_q;
  logic          err_q;
  logic          accept;

  // Gated by rst_n so the feeder never advertises readiness while held in reset.
  assign in_ready = rst_n && (state_q == ST_COLLECT);
  assign accept   = in_valid && in_ready;

  // Incoming byte merged into the block; a last byte short of the block end pulls in
  // the 0x80 marker and zero fill, overwriting stale bytes from the previous block.
  always_comb begin
    blk_buf_d = blk_buf_q;
    unique case (idx_q)
      2'd0: begin
        blk_buf_d[31:24] = in_data;
        if (in_last) blk_buf_d[23:0] = 24'h800000;
      end
      2'd1: begin
        blk_buf_d[23:16] = in_data;
        if (in_last) blk_buf_d[15:0] = 16'h8000;
      end
      2'd2: begin
        blk_buf_d[15:8] = in_data;
        if (in_last) blk_buf_d[7:0] = 8'h80;
      end
      default: blk_buf_d[7:0] = in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_COLLECT;
      idx_q          <= 2'd0;
      blk_buf_q      <= 32'h0;
      chain_q        <= IV_INIT;
      final_q        <= 1'b0;
      pad_blk_q      <= 1'b0;
      wait_cnt_q     <= '0;
      h_start_q      <= 1'b0;
      h_m_q          <= 32'h0;
      h_iv_q         <= IV_INIT;
      digest_q       <= 32'h0;
      digest_valid_q <= 1'b0;
      blk_cnt_q      <= 16'h0;
      err_q          <= 1'b0;
    end else begin
      h_start_q      <= 1'b0;
      digest_valid_q <= 1'b0;
      err_q          <= 1'b0;
      unique case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            blk_buf_q <= blk_buf_d;
            idx_q     <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q   <= ST_ISSUE;
              final_q   <= 1'b0;
              pad_blk_q <= in_last;
            end else if (in_last) begin
              state_q   <= ST_ISSUE;
              final_q   <= 1'b1;
              pad_blk_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          h_start_q  <= 1'b1;
          h_m_q      <= blk_buf_q;
          h_iv_q     <= chain_q;
          if (blk_cnt_q != 16'hFFFF) blk_cnt_q <= blk_cnt_q + 16'd1;
          idx_q      <= 2'd0;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // The first WAIT cycle coincides with the visible start pulse, so a done seen
          // then is a leftover level from an earlier operation.
          if (h_done && (wait_cnt_q != '0)) begin
            chain_q <= h_d;
            if (final_q) begin
              state_q <= ST_DONE;
            end else if (pad_blk_q) begin
              blk_buf_q <= 32'h80000000;
              final_q   <= 1'b1;
              pad_blk_q <= 1'b0;
              state_q   <= ST_ISSUE;
            end else begin
              state_q <= ST_COLLECT;
            end
          end else if (wait_cnt_q == CW'(WAIT_MAX)) begin
            err_q     <= 1'b1;
            chain_q   <= IV_INIT;
            blk_cnt_q <= 16'h0;
            final_q   <= 1'b0;
            pad_blk_q <= 1'b0;
            state_q   <= ST_COLLECT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          digest_q       <= chain_q;
          digest_valid_q <= 1'b1;
          chain_q        <= IV_INIT;
          blk_cnt_q      <= 16'h0;
          final_q        <= 1'b0;
          state_q        <= ST_COLLECT;
        end
      endcase
    end
  end

  assign h_start      = h_start_q;
  assign h_m          = h_m_q;
  assign h_iv         = h_iv_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign blk_cnt      = blk_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder; the bench plays the hash core by driving h_done/h_d.
module tb_hash_msg_feeder;

  localparam logic [31:0] IV = 32'h34550F14;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        h_start;
  logic [31:0] h_m;
  logic [31:0] h_iv;
  logic [31:0] h_d;
  logic        h_done;
  logic [31:0] digest;
  logic        digest_valid;
  logic [15:0] blk_cnt;
  logic        err;

  int nCompared;
  int nMismatched;

  hash_msg_feeder #(.IV_INIT(32'h34550F14), .WAIT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .h_start(h_start), .h_m(h_m),
    .h_iv(h_iv), .h_d(h_d), .h_done(h_done), .digest(digest),
    .digest_valid(digest_valid), .blk_cnt(blk_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for one cycle; callers only use it while the feeder is in COLLECT.
  task automatic sendByte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    nCompared++; if (h_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_h_start: got %0b want 0", h_start); end
    nCompared++; if (h_m !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_h_m: got %h want 00000000", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL reset_h_iv: got %h want %h", h_iv, IV); end
    nCompared++; if (digest !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_digest: got %h want 00000000", digest); end
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_digest_valid: got %0b want 0", digest_valid); end
    nCompared++; if (blk_cnt !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_blk_cnt: got %h want 0000", blk_cnt); end
    nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single_block();
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b1);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_issue_ready: got %0b want 0", in_ready); end
    tick();
    nCompared++; if (h_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_start: got %0b want 1", h_start); end
    nCompared++; if (h_m !== 32'h01020380) begin nMismatched++; $display("[TB] FAIL single_h_m: got %h want 01020380", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL single_h_iv: got %h want %h", h_iv, IV); end
    nCompared++; if (blk_cnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL single_blk_cnt: got %0d want 1", blk_cnt); end
    tick();
    nCompared++; if (h_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_start_pulse: got %0b want 0", h_start); end
    h_done = 1'b1;
    h_d    = 32'hA1B2C3D4;
    tick();
    h_done = 1'b0;
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_dv_early: got %0b want 0", digest_valid); end
    tick();
    nCompared++; if (digest_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_dv: got %0b want 1", digest_valid); end
    nCompared++; if (digest !== 32'hA1B2C3D4) begin nMismatched++; $display("[TB] FAIL single_digest: got %h want A1B2C3D4", digest); end
    nCompared++; if (blk_cnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL single_blk_cnt_clear: got %0d want 0", blk_cnt); end
    tick();
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_dv_pulse: got %0b want 0", digest_valid); end
    nCompared++; if (digest !== 32'hA1B2C3D4) begin nMismatched++; $display("[TB] FAIL single_digest_hold: got %h want A1B2C3D4", digest); end
  endtask

  task automatic test_pad_block();
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b1);
    tick();
    nCompared++; if (h_m !== 32'h01020304) begin nMismatched++; $display("[TB] FAIL pad_blk1_h_m: got %h want 01020304", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL pad_blk1_h_iv: got %h want %h", h_iv, IV); end
    tick();
    nCompared++; if (h_m !== 32'h01020304) begin nMismatched++; $display("[TB] FAIL pad_blk1_hold: got %h want 01020304", h_m); end
    h_done = 1'b1;
    h_d    = 32'h11223344;
    tick();
    h_done = 1'b0;
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL pad_reissue_ready: got %0b want 0", in_ready); end
    tick();
    nCompared++; if (h_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL pad_blk2_start: got %0b want 1", h_start); end
    nCompared++; if (h_m !== 32'h80000000) begin nMismatched++; $display("[TB] FAIL pad_blk2_h_m: got %h want 80000000", h_m); end
    nCompared++; if (h_iv !== 32'h11223344) begin nMismatched++; $display("[TB] FAIL pad_blk2_h_iv: got %h want 11223344", h_iv); end
    nCompared++; if (blk_cnt !== 16'd2) begin nMismatched++; $display("[TB] FAIL pad_blk_cnt: got %0d want 2", blk_cnt); end
    tick();
    h_done = 1'b1;
    h_d    = 32'h55667788;
    tick();
    h_done = 1'b0;
    tick();
    nCompared++; if (digest_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL pad_dv: got %0b want 1", digest_valid); end
    nCompared++; if (digest !== 32'h55667788) begin nMismatched++; $display("[TB] FAIL pad_digest: got %h want 55667788", digest); end
    tick();
  endtask

  task automatic test_five_bytes();
    sendByte(8'hFF, 1'b0);
    sendByte(8'hEE, 1'b0);
    sendByte(8'hDD, 1'b0);
    sendByte(8'hCC, 1'b0);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL five_ready_after_4th: got %0b want 0", in_ready); end
    tick();
    nCompared++; if (h_m !== 32'hFFEEDDCC) begin nMismatched++; $display("[TB] FAIL five_blk1_h_m: got %h want FFEEDDCC", h_m); end
    tick();
    tick();
    tick();
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL five_ready_in_wait: got %0b want 0", in_ready); end
    h_done = 1'b1;
    h_d    = 32'hDEADBEEF;
    tick();
    h_done = 1'b0;
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL five_ready_after_done: got %0b want 1", in_ready); end
    sendByte(8'hBB, 1'b1);
    tick();
    nCompared++; if (h_m !== 32'hBB800000) begin nMismatched++; $display("[TB] FAIL five_blk2_h_m: got %h want BB800000", h_m); end
    nCompared++; if (h_iv !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL five_blk2_h_iv: got %h want DEADBEEF", h_iv); end
    nCompared++; if (blk_cnt !== 16'd2) begin nMismatched++; $display("[TB] FAIL five_blk_cnt: got %0d want 2", blk_cnt); end
    tick();
    h_done = 1'b1;
    h_d    = 32'h0BADF00D;
    tick();
    h_done = 1'b0;
    tick();
    nCompared++; if (digest !== 32'h0BADF00D) begin nMismatched++; $display("[TB] FAIL five_digest: got %h want 0BADF00D", digest); end
    tick();
  endtask

  task automatic test_back_to_back();
    sendByte(8'h01, 1'b1);
    tick();
    nCompared++; if (h_m !== 32'h01800000) begin nMismatched++; $display("[TB] FAIL b2b_msg1_h_m: got %h want 01800000", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL b2b_msg1_h_iv: got %h want %h", h_iv, IV); end
    tick();
    h_done = 1'b1;
    h_d    = 32'hCAFE0001;
    tick();
    h_done = 1'b0;
    tick();
    nCompared++; if (digest_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_dv1: got %0b want 1", digest_valid); end
    nCompared++; if (digest !== 32'hCAFE0001) begin nMismatched++; $display("[TB] FAIL b2b_digest1: got %h want CAFE0001", digest); end
    sendByte(8'h02, 1'b1);
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_dv1_pulse: got %0b want 0", digest_valid); end
    tick();
    nCompared++; if (h_m !== 32'h02800000) begin nMismatched++; $display("[TB] FAIL b2b_msg2_h_m: got %h want 02800000", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL b2b_msg2_h_iv: got %h want %h", h_iv, IV); end
    tick();
    h_done = 1'b1;
    h_d    = 32'hCAFE0002;
    tick();
    h_done = 1'b0;
    tick();
    nCompared++; if (digest_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_dv2: got %0b want 1", digest_valid); end
    nCompared++; if (digest !== 32'hCAFE0002) begin nMismatched++; $display("[TB] FAIL b2b_digest2: got %h want CAFE0002", digest); end
    tick();
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_dv2_pulse: got %0b want 0", digest_valid); end
  endtask

  task automatic test_timeout();
    sendByte(8'h5A, 1'b1);
    h_done = 1'b1;
    h_d    = 32'h99999999;
    tick();
    nCompared++; if (h_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_start: got %0b want 1", h_start); end
    tick();
    h_done = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_err_early: got %0b want 0", err); end
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_still_wait: got %0b want 0", in_ready); end
    tick();
    nCompared++; if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_err: got %0b want 1", err); end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_collect: got %0b want 1", in_ready); end
    nCompared++; if (blk_cnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL timeout_blk_cnt: got %0d want 0", blk_cnt); end
    nCompared++; if (digest !== 32'hCAFE0002) begin nMismatched++; $display("[TB] FAIL timeout_digest: got %h want CAFE0002", digest); end
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_dv: got %0b want 0", digest_valid); end
    tick();
    nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_err_pulse: got %0b want 0", err); end
    sendByte(8'h77, 1'b1);
    tick();
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL timeout_chain_reset: got %h want %h", h_iv, IV); end
    tick();
    h_done = 1'b1;
    h_d    = 32'h12121212;
    tick();
    h_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_message();
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b0);
    tick();
    nCompared++; if (h_m !== 32'h01020304) begin nMismatched++; $display("[TB] FAIL midrst_pre_h_m: got %h want 01020304", h_m); end
    rst_n = 1'b0;
    #1;
    nCompared++; if (h_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_h_start: got %0b want 0", h_start); end
    nCompared++; if (h_m !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_h_m: got %h want 00000000", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL midrst_h_iv: got %h want %h", h_iv, IV); end
    nCompared++; if (digest !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_digest: got %h want 00000000", digest); end
    nCompared++; if (blk_cnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL midrst_blk_cnt: got %0d want 0", blk_cnt); end
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_in_ready: got %0b want 0", in_ready); end
    tick();
    rst_n = 1'b1;
    h_done = 1'b1;
    h_d    = 32'hFFFFFFFF;
    tick();
    tick();
    h_done = 1'b0;
    tick();
    nCompared++; if (digest_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_stray_done_dv: got %0b want 0", digest_valid); end
    nCompared++; if (digest !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_stray_done_digest: got %h want 00000000", digest); end
    sendByte(8'h0A, 1'b1);
    tick();
    nCompared++; if (h_m !== 32'h0A800000) begin nMismatched++; $display("[TB] FAIL midrst_new_h_m: got %h want 0A800000", h_m); end
    nCompared++; if (h_iv !== IV) begin nMismatched++; $display("[TB] FAIL midrst_new_h_iv: got %h want %h", h_iv, IV); end
    nCompared++; if (blk_cnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL midrst_new_blk_cnt: got %0d want 1", blk_cnt); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_last     = 1'b0;
    h_d         = 32'h0;
    h_done      = 1'b0;
    rst_n       = 1'b1;
    #1;
    test_reset();
    test_single_block();
    test_pad_block();
    test_five_bytes();
    test_back_to_back();
    test_timeout();
    test_reset_mid_message();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
